// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: takes one command at a time and runs SINGLE or INCR4/8/16
// transfers with pipelined address/data phases, wait states and two-cycle ERROR handling.
module ahb_burst_master #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [2:0]        cmd_size,
  input  logic              cmd_lock,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  input  logic              hreadyout,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  output logic [DATA_W-1:0] hwdata,
  output logic              hready
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;

  state_t            state;
  logic [3:0]        beats_left;
  logic              dphase;
  logic              dphase_write;
  logic [3:0]        len_m1;
  logic [2:0]        burst_code;
  logic              addr_done;
  logic [ADDR_W-1:0] incr;

  // Unsupported burst codes collapse to a SINGLE transfer.
  always_comb begin
    len_m1     = 4'd0;
    burst_code = 3'b000;
    case (cmd_burst)
      3'b011:  begin len_m1 = 4'd3;  burst_code = 3'b011; end
      3'b101:  begin len_m1 = 4'd7;  burst_code = 3'b101; end
      3'b111:  begin len_m1 = 4'd15; burst_code = 3'b111; end
      default: begin len_m1 = 4'd0;  burst_code = 3'b000; end
    endcase
  end

  assign addr_done = (htrans != TRANS_IDLE) && hreadyout;
  assign incr      = {{(ADDR_W-1){1'b0}}, 1'b1} << hsize;
  assign cmd_ready = (state == S_IDLE);
  assign wdata_ack = addr_done && hwrite;
  assign hready    = hreadyout;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state        <= S_IDLE;
      beats_left   <= '0;
      dphase       <= 1'b0;
      dphase_write <= 1'b0;
      haddr        <= '0;
      htrans       <= TRANS_IDLE;
      hwrite       <= 1'b0;
      hsize        <= '0;
      hburst       <= '0;
      hprot        <= '0;
      hmastlock    <= 1'b0;
      hwdata       <= '0;
      rdata_out    <= '0;
      rdata_valid  <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      // Track which beat occupies the data phase; it only advances when the slave is ready.
      if (hreadyout) begin
        dphase       <= (htrans != TRANS_IDLE);
        dphase_write <= hwrite;
      end
      if (addr_done && hwrite)
        hwdata <= wdata_in;
      if (dphase && !dphase_write && hreadyout && !hresp && state != S_ERR) begin
        rdata_out   <= hrdata;
        rdata_valid <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state      <= S_ADDR;
            htrans     <= TRANS_NONSEQ;
            haddr      <= cmd_addr;
            hwrite     <= cmd_write;
            hsize      <= cmd_size;
            hburst     <= burst_code;
            hprot      <= HPROT_VAL;
            hmastlock  <= cmd_lock;
            beats_left <= len_m1;
          end
        end
        S_ADDR, S_BURST: begin
          // First ERROR cycle: drop the pending address by driving IDLE next cycle.
          if (dphase && hresp && !hreadyout) begin
            state  <= S_ERR;
            htrans <= TRANS_IDLE;
          end else if (hreadyout) begin
            if (beats_left == 4'd0) begin
              state  <= S_LAST;
              htrans <= TRANS_IDLE;
            end else begin
              state      <= S_BURST;
              htrans     <= TRANS_SEQ;
              haddr      <= haddr + incr;
              beats_left <= beats_left - 4'd1;
            end
          end
        end
        S_LAST: begin
          if (hreadyout) begin
            state     <= S_IDLE;
            done      <= 1'b1;
            err       <= hresp;
            hprot     <= '0;
            hmastlock <= 1'b0;
          end else if (hresp) begin
            state <= S_ERR;
          end
        end
        S_ERR: begin
          if (hreadyout) begin
            state     <= S_IDLE;
            done      <= 1'b1;
            err       <= 1'b1;
            hprot     <= '0;
            hmastlock <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: a small AHB slave model plus hand-computed
// expectations for SINGLE, INCR bursts, wait states, ERROR aborts and reset.
module tb_ahb_burst_master;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_lock;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst, cmd_size;
  logic [31:0] wdata_in;
  logic        wdata_ack;
  logic [31:0] rdata_out;
  logic        rdata_valid, done, err;
  logic        hreadyout, hresp;
  logic [31:0] hrdata, haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite, hmastlock, hready;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  int          check_count = 0;
  int          error_count = 0;
  int          ack_cnt = 0, rv_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [31:0] rd_q[$];
  logic [31:0] dp_addr = '0;
  logic        fixed_data = 1'b0;
  logic [31:0] fixed_word = '0;

  always #5 hclk = ~hclk;

  ahb_burst_master #(.ADDR_W(32), .DATA_W(32), .HPROT_VAL(4'b0011)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_lock(cmd_lock),
    .wdata_in(wdata_in), .wdata_ack(wdata_ack),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .done(done), .err(err),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata), .hready(hready)
  );

  // Slave returns a word derived from the address of the beat in its data phase.
  assign hrdata   = {16'hA5A5, dp_addr[15:0]};
  assign wdata_in = fixed_data ? fixed_word : (32'hC0DE_0000 + 32'(ack_cnt));

  always @(posedge hclk) begin
    if (hreadyout && htrans != 2'b00) dp_addr <= haddr;
    if (wdata_ack)   ack_cnt  <= ack_cnt + 1;
    if (done)        done_cnt <= done_cnt + 1;
    if (err)         err_cnt  <= err_cnt + 1;
    if (rdata_valid) begin
      rv_cnt <= rv_cnt + 1;
      rd_q.push_back(rdata_out);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents a command for one cycle; returns mid-way through the first address phase.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [2:0] burst,
                               input logic [2:0] size, input logic lock);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_burst = burst;
    cmd_size  = size;
    cmd_lock  = lock;
    @(negedge hclk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ack0, rv0, done0, err0, q0;
    logic [31:0] last_addr;
    logic        seen_done;

    hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_burst = '0; cmd_size = '0; cmd_lock = 1'b0; hreadyout = 1'b1; hresp = 1'b0;
    repeat (2) @(negedge hclk);
    checkOutput("rst_htrans", htrans, 2'b00);
    checkOutput("rst_haddr", haddr, 32'h0);
    checkOutput("rst_hprot_lock", {hprot, hmastlock}, 5'h0);
    checkOutput("rst_hwdata_rdata", {hwdata, rdata_out}, 64'h0);
    checkOutput("rst_pulses", {done, err, rdata_valid, wdata_ack}, 4'b0000);
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    hresetn = 1'b1;
    @(negedge hclk);

    $display("[TB] SINGLE write");
    ack0 = ack_cnt; err0 = err_cnt;
    fixed_data = 1'b1; fixed_word = 32'hDEADBEEF;
    applyStimulus(1'b1, 32'h100, 3'b000, 3'b010, 1'b0);
    checkOutput("single_c1_trans_addr", {htrans, haddr}, {2'b10, 32'h100});
    checkOutput("single_c1_hwrite_ack", {hwrite, wdata_ack}, 2'b11);
    @(negedge hclk);
    checkOutput("single_c2_hwdata", hwdata, 32'hDEADBEEF);
    checkOutput("single_c2_trans_done", {htrans, done}, 3'b000);
    @(negedge hclk);
    checkOutput("single_c3_done_err", {done, err}, 2'b10);
    checkOutput("single_c3_cmd_ready", cmd_ready, 1'b1);
    @(negedge hclk);
    fixed_data = 1'b0;
    checkOutput("single_ack_count", 32'(ack_cnt - ack0), 32'd1);
    checkOutput("single_err_count", 32'(err_cnt - err0), 32'd0);

    $display("[TB] INCR4 read");
    rv0 = rv_cnt; q0 = rd_q.size();
    applyStimulus(1'b0, 32'h40, 3'b011, 3'b010, 1'b0);
    checkOutput("incr4_c1", {htrans, haddr}, {2'b10, 32'h40});
    checkOutput("incr4_busy_ready", cmd_ready, 1'b0);
    for (int k = 1; k < 4; k++) begin
      @(negedge hclk);
      checkOutput($sformatf("incr4_c%0d", k + 1), {htrans, haddr}, {2'b11, 32'h40 + 32'(4 * k)});
    end
    @(negedge hclk);
    checkOutput("incr4_c5_idle", {htrans, done}, 3'b000);
    @(negedge hclk);
    checkOutput("incr4_c6_done", {done, err}, 2'b10);
    @(negedge hclk);
    checkOutput("incr4_rv_count", 32'(rv_cnt - rv0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (rd_q.size() > q0 + k)
        checkOutput($sformatf("incr4_rdata%0d", k), rd_q[q0 + k], 32'hA5A5_0040 + 32'(4 * k));
      else
        checkOutput($sformatf("incr4_rdata%0d_missing", k), 1'b0, 1'b1);
    end

    $display("[TB] INCR8 write with waits");
    ack0 = ack_cnt;
    applyStimulus(1'b1, 32'h15, 3'b101, 3'b000, 1'b0);
    checkOutput("incr8_c1", {htrans, haddr, hburst, hsize}, {2'b10, 32'h15, 3'b101, 3'b000});
    repeat (3) @(negedge hclk);
    hreadyout = 1'b0;
    checkOutput("incr8_wait0", {haddr, hwdata}, {32'h18, 32'hC0DE_0000 + 32'(ack0 + 2)});
    @(negedge hclk);
    checkOutput("incr8_wait1", {haddr, hwdata}, {32'h18, 32'hC0DE_0000 + 32'(ack0 + 2)});
    checkOutput("incr8_wait_ack", wdata_ack, 1'b0);
    @(negedge hclk);
    hreadyout = 1'b1;
    checkOutput("incr8_wait2", {haddr, hwdata}, {32'h18, 32'hC0DE_0000 + 32'(ack0 + 2)});
    last_addr = haddr;
    seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      @(negedge hclk);
      if (htrans != 2'b00) last_addr = haddr;
      if (done) seen_done = 1'b1;
    end
    checkOutput("incr8_done_seen", seen_done, 1'b1);
    checkOutput("incr8_last_addr", last_addr, 32'h1C);
    @(negedge hclk);
    checkOutput("incr8_ack_count", 32'(ack_cnt - ack0), 32'd8);

    $display("[TB] INCR16 read with ERROR on beat 2");
    rv0 = rv_cnt; done0 = done_cnt; err0 = err_cnt;
    applyStimulus(1'b0, 32'h200, 3'b111, 3'b010, 1'b0);
    repeat (2) @(negedge hclk);
    checkOutput("err_c3_trans", {htrans, haddr}, {2'b11, 32'h208});
    hresp = 1'b1; hreadyout = 1'b0;
    @(negedge hclk);
    checkOutput("err_c4_cancel", {htrans, done}, 3'b000);
    hreadyout = 1'b1;
    @(negedge hclk);
    hresp = 1'b0;
    checkOutput("err_c5_done_err", {done, err}, 2'b11);
    @(negedge hclk);
    checkOutput("err_rv_count", 32'(rv_cnt - rv0), 32'd1);
    checkOutput("err_done_err_count", {32'(done_cnt - done0), 32'(err_cnt - err0)}, {32'd1, 32'd1});
    checkOutput("err_cmd_ready", cmd_ready, 1'b1);

    $display("[TB] illegal burst code with lock");
    applyStimulus(1'b1, 32'h300, 3'b010, 3'b010, 1'b1);
    checkOutput("lock_c1", {htrans, hburst, hmastlock, hprot}, {2'b10, 3'b000, 1'b1, 4'b0011});
    @(negedge hclk);
    checkOutput("lock_c2", {htrans, hmastlock}, {2'b00, 1'b1});
    @(negedge hclk);
    checkOutput("lock_c3", {done, hmastlock, hprot}, {1'b1, 1'b0, 4'b0000});
    @(negedge hclk);

    $display("[TB] reset mid-burst");
    done0 = done_cnt; err0 = err_cnt;
    applyStimulus(1'b0, 32'h80, 3'b101, 3'b010, 1'b0);
    repeat (3) @(negedge hclk);
    hresetn = 1'b0;
    #1;
    checkOutput("mid_rst_bus", {htrans, haddr, hmastlock, hprot}, 39'h0);
    checkOutput("mid_rst_rdata", {rdata_out, rdata_valid, done, err}, 35'h0);
    checkOutput("mid_rst_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    repeat (12) @(negedge hclk);
    checkOutput("mid_rst_no_done", {32'(done_cnt - done0), 32'(err_cnt - err0)}, 64'h0);
    checkOutput("mid_rst_idle", {cmd_ready, htrans}, 3'b100);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
